// File: rtl/seg7_scan_decoder_pkg.sv
// seg7_pkg: definitions shared by the 7-segment scan decoder and the display
// driver, so that encoding and decoding always use the same table.
//   scan_state_t : frame reassembly states
//   HEX_SEG      : active-high gfedcba pattern for each hex nibble
//   seg_decode() : pattern -> {valid, nibble}; unknown patterns give nibble 0
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } scan_state_t;

  // Packed array, element [15] first: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } seg_decode_t;

  function automatic seg_decode_t seg_decode(input logic [6:0] seg_on);
    seg_decode_t r;
    r.valid  = 1'b0;
    r.nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (HEX_SEG[i] == seg_on) begin
        r.valid  = 1'b1;
        r.nibble = i[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: the scanned 7-segment pin bundle.
//   SEG[7:0] : segments, active low (SEG[0]=a .. SEG[6]=g, SEG[7]=dp)
//   AN[7:0]  : digit enables, active low (AN[i] selects digit i)
// master drives the pins (display driver / bench), slave observes them.
interface seg7_scan_decoder_if;
  logic [7:0] SEG;
  logic [7:0] AN;

  modport master (output SEG, output AN);
  modport slave  (input SEG, input AN);
endinterface

// File: rtl/seg7_scan_decoder_sample.sv
// seg7_sample_filter: registers the SEG/AN pins and emits a one-cycle accept
// strobe the first cycle a pattern has been seen STABLE_CYCLES times in a row.
//   clk, RST       : clock, synchronous active-low reset
//   seg_in, an_in  : raw pins
//   accept         : one-shot strobe, aligned with seg_acc/an_acc
//   seg_acc, an_acc: the registered sample (valid while accept is high)
module seg7_sample_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] seg_in,
  input  logic [7:0] an_in,
  output logic       accept,
  output logic [7:0] seg_acc,
  output logic [7:0] an_acc
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);

  logic [15:0]   sample_reg;
  logic [RW-1:0] run_reg;
  logic          same;

  assign same    = ({seg_in, an_in} == sample_reg);
  assign seg_acc = sample_reg[15:8];
  assign an_acc  = sample_reg[7:0];

  always_ff @(posedge clk) begin
    if (!RST) begin
      sample_reg <= 16'h0000;
      run_reg    <= '0;
      accept     <= 1'b0;
    end else begin
      sample_reg <= {seg_in, an_in};
      if (!same)
        run_reg <= RW'(1);
      else if (run_reg != RW'(STABLE_CYCLES))
        run_reg <= run_reg + 1'b1;
      // Fires exactly when the run counter steps onto STABLE_CYCLES, so a
      // long hold (saturated counter) is accepted only once.
      accept <= same && (run_reg == RW'(STABLE_CYCLES - 1));
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reads back a multiplexed 8-digit 7-segment display.
// Debounced digits are decoded to nibbles and assembled into a 32-bit word.
//   clk, RST    : clock, synchronous active-low reset
//   pins        : SEG/AN pin bundle (slave)
//   clear_err   : clears digit_err (a same-cycle error set wins)
//   value       : last complete frame, nibble i from digit i
//   dp_mask     : last complete frame's decimal points
//   frame_valid : one-cycle pulse when value/dp_mask update
//   digit_err   : sticky, set on undecodable pattern or multiple AN low
//   lost_sync   : one-cycle pulse when a stalled partial frame is dropped
import seg7_pkg::*;

module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 RST,
  seg7_scan_decoder_if.slave   pins,
  input  logic                 clear_err,
  output logic [31:0]          value,
  output logic [7:0]           dp_mask,
  output logic                 frame_valid,
  output logic                 digit_err,
  output logic                 lost_sync
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic        accept;
  logic [7:0]  seg_acc;
  logic [7:0]  an_acc;

  seg7_sample_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk     (clk),
    .RST     (RST),
    .seg_in  (pins.SEG),
    .an_in   (pins.AN),
    .accept  (accept),
    .seg_acc (seg_acc),
    .an_acc  (an_acc)
  );

  logic [7:0]  digit_on;
  logic [2:0]  idx;
  logic [7:0]  idx_bit;
  seg_decode_t dec;
  logic        dp_bit;
  logic        valid_acc;
  logic        err_set;

  assign digit_on  = ~an_acc;
  assign dec       = seg_decode(~seg_acc[6:0]);
  assign dp_bit    = ~seg_acc[7];
  assign valid_acc = accept && $onehot(digit_on);
  // Blank (no digit enabled) is silently ignored; several enabled is an error.
  assign err_set   = (accept && (digit_on != 8'h00) && !$onehot(digit_on)) ||
                     (valid_acc && !dec.valid);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (digit_on[i]) idx = i[2:0];
  end

  assign idx_bit = 8'h01 << idx;

  scan_state_t   state_reg;
  logic [7:0]    seen_reg;
  logic [31:0]   shadow_val_reg;
  logic [7:0]    shadow_dp_reg;
  logic [IW-1:0] idle_reg;

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_reg      <= ST_SYNC;
      seen_reg       <= 8'h00;
      shadow_val_reg <= 32'h0;
      shadow_dp_reg  <= 8'h00;
      idle_reg       <= '0;
      value          <= 32'h0;
      dp_mask        <= 8'h00;
      frame_valid    <= 1'b0;
      digit_err      <= 1'b0;
      lost_sync      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      lost_sync   <= 1'b0;

      if (err_set)
        digit_err <= 1'b1;
      else if (clear_err)
        digit_err <= 1'b0;

      if (valid_acc)
        idle_reg <= '0;
      else if (idle_reg != IW'(TIMEOUT_CYCLES))
        idle_reg <= idle_reg + 1'b1;

      case (state_reg)
        ST_SYNC: begin
          if (valid_acc && idx == 3'd0) begin
            shadow_val_reg[3:0] <= dec.nibble;
            shadow_dp_reg[0]    <= dp_bit;
            seen_reg            <= 8'h01;
            state_reg           <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (valid_acc) begin
            if (idx == 3'd0) begin
              shadow_val_reg[3:0] <= dec.nibble;
              shadow_dp_reg[0]    <= dp_bit;
              seen_reg            <= 8'h01;
            end else if (seen_reg != 8'h00) begin
              // seen == 0 right after a frame: wait for digit 0 like SYNC.
              shadow_val_reg[{idx, 2'b00} +: 4] <= dec.nibble;
              shadow_dp_reg[idx]                <= dp_bit;
              seen_reg                          <= seen_reg | idx_bit;
              if ((seen_reg | idx_bit) == 8'hFF)
                state_reg <= ST_DONE;
            end
          end else if (idle_reg == IW'(TIMEOUT_CYCLES) && seen_reg != 8'h00) begin
            shadow_val_reg <= 32'h0;
            shadow_dp_reg  <= 8'h00;
            seen_reg       <= 8'h00;
            lost_sync      <= 1'b1;
            state_reg      <= ST_SYNC;
          end
        end

        ST_DONE: begin
          value       <= shadow_val_reg;
          dp_mask     <= shadow_dp_reg;
          frame_valid <= 1'b1;
          seen_reg    <= 8'h00;
          state_reg   <= ST_COLLECT;
          // A digit 0 landing here starts the next frame immediately.
          if (valid_acc && idx == 3'd0) begin
            shadow_val_reg[3:0] <= dec.nibble;
            shadow_dp_reg[0]    <= dp_bit;
            seen_reg            <= 8'h01;
          end
        end

        default: state_reg <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder. Pins are driven as a list of held patterns; a
// pattern-level model (held-run length, digit index, hex table lookup)
// predicts every frame, its arrival cycle, digit_err and lost_sync pulses.
module tb_seg7_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        frame_valid;
  logic        digit_err;
  logic        lost_sync;

  seg7_scan_decoder_if pins();

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .RST         (rst_n),
    .pins        (pins),
    .clear_err   (clear_err),
    .value       (value),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .digit_err   (digit_err),
    .lost_sync   (lost_sync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hex_code [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [31:0] v;
    logic [7:0]  dp;
    int          at;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] m_prev = 16'h0;
  bit          m_prev_ok = 0;
  int          m_run_start = 0;
  bit          m_run_acc = 0;
  logic [7:0]  m_seen = 8'h00;
  logic [31:0] m_val = 32'h0;
  logic [7:0]  m_dp = 8'h00;
  bit          m_err = 0;
  int          m_lost = 0;
  int          obs_lost = 0;

  task automatic model_accept(input logic [15:0] pat, input int run_start);
    logic [7:0] on;
    logic [6:0] code;
    int         n, d;
    logic [3:0] nib;
    bit         found;
    on = ~pat[7:0];
    n = $countones(on);
    if (n == 0) return;
    if (n > 1) begin
      m_err = 1;
      return;
    end
    d = 0;
    for (int i = 0; i < 8; i++) if (on[i]) d = i;
    code = ~pat[14:8];
    found = 0;
    nib = 4'h0;
    for (int k = 0; k < 16; k++)
      if (hex_code[k] == code) begin
        found = 1;
        nib = 4'(k);
      end
    if (!found) m_err = 1;
    if (d == 0) begin
      m_seen = 8'h01;
      m_val[3:0] = nib;
      m_dp[0] = ~pat[15];
    end else if (m_seen != 8'h00) begin
      m_seen[d] = 1'b1;
      m_val[4*d +: 4] = nib;
      m_dp[d] = ~pat[15];
      if (m_seen == 8'hFF) begin
        exp_q.push_back('{v: m_val, dp: m_dp, at: run_start + STABLE + 1});
        m_seen = 8'h00;
      end
    end
  endtask

  // Called at a falling edge; the pattern is sampled on the next h rising edges.
  task automatic drive_seg(input logic [7:0] seg, input logic [7:0] an, input int h);
    logic [15:0] pat;
    int s;
    s = cyc + 1;
    pat = {seg, an};
    if (!m_prev_ok || pat != m_prev) begin
      m_prev = pat;
      m_prev_ok = 1;
      m_run_start = s;
      m_run_acc = 0;
    end
    if (!m_run_acc && (s + h - m_run_start) >= STABLE) begin
      m_run_acc = 1;
      model_accept(pat, m_run_start);
    end
    pins.SEG = seg;
    pins.AN  = an;
    repeat (h) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_digit(input int d, input logic [3:0] nib, input bit dp, input int h);
    logic [7:0] one;
    one = 8'h01 << d;
    drive_seg(~{dp, hex_code[nib]}, ~one, h);
  endtask

  task automatic scan(input logic [31:0] v, input logic [7:0] dpm,
                      input int first, input int last, input bit glitches);
    for (int d = first; d <= last; d++) begin
      if (glitches && $urandom_range(0, 3) == 0)
        drive_seg(8'($urandom), 8'($urandom), $urandom_range(1, STABLE - 1));
      drive_digit(d, v[4*d +: 4], dpm[d], $urandom_range(STABLE, STABLE + 3));
    end
  endtask

  task automatic stall();
    if (m_seen != 8'h00) begin
      m_lost++;
      m_seen = 8'h00;
    end
    drive_seg(8'hFF, 8'hFF, 3 * TIMEOUT);
  endtask

  task automatic settle_and_check(input string tag);
    drive_seg(8'hFF, 8'hFF, 8);
    #1;
    check_eq({tag, "_digit_err"}, 32'(digit_err), 32'(m_err));
    check_eq({tag, "_lost_sync"}, 32'(obs_lost), 32'(m_lost));
    check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_err = 1'b0;
    m_err = 0;
    #1;
    check_eq("clear_err", 32'(digit_err), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_eq("rst_value", value, 32'h0);
    check_eq("rst_dp_mask", 32'(dp_mask), 32'h0);
    check_eq("rst_frame_valid", 32'(frame_valid), 32'h0);
    check_eq("rst_digit_err", 32'(digit_err), 32'h0);
    check_eq("rst_lost_sync", 32'(lost_sync), 32'h0);
    rst_n = 1'b1;
    m_prev_ok = 0;
    m_seen = 8'h00;
    m_err = 0;
    m_lost = 0;
    obs_lost = 0;
    exp_q.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (lost_sync) obs_lost++;
      if (frame_valid) begin
        $display("frame cycle=%0d value=%h dp_mask=%h", cyc, value, dp_mask);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'(frame_valid), 32'd0);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check_eq("frame_cycle", cyc, e.at);
          check_eq("value", value, e.v);
          check_eq("dp_mask", 32'(dp_mask), 32'(e.dp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    pins.SEG = 8'hFF;
    pins.AN  = 8'hFF;
    @(negedge clk);
    do_reset(4);

    scan(32'h1234ABCD, 8'h00, 0, 7, 0);
    settle_and_check("plain");
    scan(32'h1234ABCD, 8'h08, 0, 7, 0);
    settle_and_check("dp3");

    scan(32'h89ABCDEF, 8'h00, 3, 7, 0);
    scan(32'h13579BDF, 8'h81, 0, 7, 0);
    settle_and_check("late_start");

    for (int d = 0; d < 8; d++) begin
      if (d == 5) drive_seg(8'h80, 8'hFB, 2);
      drive_digit(d, 4'(d + 8), 1'b0, 6);
    end
    settle_and_check("glitch");

    for (int d = 0; d < 8; d++) begin
      if (d == 5) drive_seg(8'hFF, 8'hDF, 6);
      else drive_digit(d, 4'hE, 1'b0, 6);
    end
    settle_and_check("blank_digit");
    pulse_clear();
    drive_seg(~{1'b0, hex_code[1]}, 8'hFC, 6);
    settle_and_check("two_an");
    pulse_clear();

    scan(32'hCAFEF00D, 8'h00, 0, 4, 0);
    stall();
    scan(32'hCAFEF00D, 8'h00, 5, 7, 0);
    settle_and_check("timeout");
    scan(32'h0BADBEEF, 8'h10, 0, 7, 0);
    settle_and_check("after_timeout");

    scan(32'h76543210, 8'h00, 0, 5, 0);
    drive_digit(6, 4'h6, 1'b0, 2);
    do_reset(3);
    drive_digit(6, 4'h6, 1'b0, 6);
    drive_digit(7, 4'h7, 1'b0, 6);
    settle_and_check("mid_reset");
    scan(32'h76543210, 8'h00, 0, 7, 0);
    settle_and_check("post_reset");

    for (int n = 0; n < 24; n++) begin
      scan($urandom, 8'($urandom), $urandom_range(0, 2) == 0 ? $urandom_range(1, 7) : 0, 7, 1);
    end
    settle_and_check("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
